// File: rtl/cdma_dc_rsp_unpack_if.sv
// Bus bundle for the DC response unpacker: descriptor pop port, DMA response
// beat port and the single-entry CBUF write port.
interface cdma_dc_rsp_unpack_if #(
    parameter int DW = 256,
    parameter int AW = 12
);
    logic              info_valid;
    logic              info_ready;
    logic [5:0]        info_pd;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [2*DW-1:0]   rsp_pd;
    logic              cbuf_wr_en;
    logic [AW-1:0]     cbuf_wr_addr;
    logic [DW-1:0]     cbuf_wr_data;

    // Unpacker side: consumes descriptors/beats, produces CBUF writes.
    modport slave (
        input  info_valid, info_pd, rsp_valid, rsp_pd,
        output info_ready, rsp_ready, cbuf_wr_en, cbuf_wr_addr, cbuf_wr_data
    );

    // Environment side: supplies descriptors/beats, observes CBUF writes.
    modport master (
        output info_valid, info_pd, rsp_valid, rsp_pd,
        input  info_ready, rsp_ready, cbuf_wr_en, cbuf_wr_addr, cbuf_wr_data
    );
endinterface

// File: rtl/cdma_dc_rsp_unpack.sv
// Pairs each request-info descriptor with one DMA response beat and unpacks
// the valid halves of the beat into single-entry writes to a CBUF ring region.
// A two-half beat takes two cycles (RUN then HI); everything else takes one.
module cdma_dc_rsp_unpack #(
    parameter int DW = 256,
    parameter int AW = 12
) (
    input  logic                   clk,
    input  logic                   reset_,
    input  logic                   op_en,
    input  logic [AW-1:0]          cfg_base_addr,
    input  logic [AW:0]            cfg_buf_entries,
    cdma_dc_rsp_unpack_if.slave    bus,
    output logic                   stripe_done,
    output logic [15:0]            line_cnt,
    output logic [15:0]            wr_entry_cnt,
    output logic                   err_mask_zero,
    output logic                   busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HI   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            op_en_q;
    logic [AW-1:0]   offset_q, offset_d;
    logic [DW-1:0]   hold_q, hold_d;
    logic            hold_eol_q, hold_eol_d;
    logic            hold_eos_q, hold_eos_d;
    logic            wr_en_q, wr_en_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic [DW-1:0]   wr_data_q, wr_data_d;
    logic            stripe_done_q, stripe_done_d;
    logic [15:0]     line_cnt_q, line_cnt_d;
    logic [15:0]     wr_cnt_q, wr_cnt_d;
    logic            err_q, err_d;

    logic [AW:0]     size_eff;
    logic [AW:0]     offset_inc;
    logic [AW-1:0]   offset_adv;
    logic [AW-1:0]   cur_addr;
    logic            acc;
    logic [1:0]      mask;
    logic            eol;
    logic            eos;
    logic [DW-1:0]   rsp_lo;
    logic [DW-1:0]   rsp_hi;
    logic            unused_pd;

    // A zero entry count encodes the full 2^AW address space.
    assign size_eff   = (cfg_buf_entries == '0) ? {1'b1, {AW{1'b0}}} : cfg_buf_entries;
    assign offset_inc = {1'b0, offset_q} + {{AW{1'b0}}, 1'b1};
    assign offset_adv = (offset_inc == size_eff) ? '0 : offset_inc[AW-1:0];
    assign cur_addr   = cfg_base_addr + offset_q;

    assign mask      = bus.info_pd[1:0];
    assign eol       = bus.info_pd[2];
    assign eos       = bus.info_pd[3];
    assign unused_pd = ^bus.info_pd[5:4];
    assign rsp_lo    = bus.rsp_pd[DW-1:0];
    assign rsp_hi    = bus.rsp_pd[2*DW-1:DW];

    // Descriptor and beat are only ever consumed together, so each ready
    // depends on the other side's valid.
    assign acc            = (state_q == S_RUN) && bus.info_valid && bus.rsp_valid && op_en;
    assign bus.info_ready = (state_q == S_RUN) && bus.rsp_valid && op_en;
    assign bus.rsp_ready  = (state_q == S_RUN) && bus.info_valid && op_en;

    assign bus.cbuf_wr_en   = wr_en_q;
    assign bus.cbuf_wr_addr = wr_addr_q;
    assign bus.cbuf_wr_data = wr_data_q;
    assign stripe_done      = stripe_done_q;
    assign line_cnt         = line_cnt_q;
    assign wr_entry_cnt     = wr_cnt_q;
    assign err_mask_zero    = err_q;
    assign busy             = (state_q != S_IDLE);

    // Next-state, next write and status counter computation.
    always_comb begin
        state_d       = state_q;
        offset_d      = offset_q;
        hold_d        = hold_q;
        hold_eol_d    = hold_eol_q;
        hold_eos_d    = hold_eos_q;
        wr_en_d       = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        stripe_done_d = 1'b0;
        line_cnt_d    = line_cnt_q;
        wr_cnt_d      = wr_cnt_q;
        err_d         = err_q;

        case (state_q)
            S_IDLE: begin
                if (op_en && !op_en_q) begin
                    offset_d   = '0;
                    line_cnt_d = '0;
                    wr_cnt_d   = '0;
                    err_d      = 1'b0;
                    state_d    = S_RUN;
                end
            end
            S_RUN: begin
                if (!op_en) begin
                    state_d = S_IDLE;
                end else if (acc) begin
                    if (mask == 2'b00) begin
                        // Nothing to write, but line/stripe markers still count.
                        err_d         = 1'b1;
                        stripe_done_d = eos;
                        if (eol) line_cnt_d = line_cnt_q + 16'd1;
                    end else if (mask == 2'b11) begin
                        // Lower half now; upper half and markers wait for HI.
                        wr_en_d    = 1'b1;
                        wr_addr_d  = cur_addr;
                        wr_data_d  = rsp_lo;
                        offset_d   = offset_adv;
                        hold_d     = rsp_hi;
                        hold_eol_d = eol;
                        hold_eos_d = eos;
                        state_d    = S_HI;
                    end else begin
                        wr_en_d       = 1'b1;
                        wr_addr_d     = cur_addr;
                        wr_data_d     = mask[0] ? rsp_lo : rsp_hi;
                        offset_d      = offset_adv;
                        stripe_done_d = eos;
                        if (eol) line_cnt_d = line_cnt_q + 16'd1;
                    end
                end
            end
            S_HI: begin
                // The second half always completes, whatever op_en does.
                wr_en_d       = 1'b1;
                wr_addr_d     = cur_addr;
                wr_data_d     = hold_q;
                offset_d      = offset_adv;
                stripe_done_d = hold_eos_q;
                if (hold_eol_q) line_cnt_d = line_cnt_q + 16'd1;
                state_d       = op_en ? S_RUN : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Count lands in the same cycle the write becomes visible.
        if (wr_en_d && (wr_cnt_q != 16'hFFFF)) begin
            wr_cnt_d = wr_cnt_q + 16'd1;
        end
    end

    // State, write pipeline and status registers.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q       <= S_IDLE;
            op_en_q       <= 1'b0;
            offset_q      <= '0;
            hold_q        <= '0;
            hold_eol_q    <= 1'b0;
            hold_eos_q    <= 1'b0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            stripe_done_q <= 1'b0;
            line_cnt_q    <= '0;
            wr_cnt_q      <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_en_q       <= op_en;
            offset_q      <= offset_d;
            hold_q        <= hold_d;
            hold_eol_q    <= hold_eol_d;
            hold_eos_q    <= hold_eos_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            stripe_done_q <= stripe_done_d;
            line_cnt_q    <= line_cnt_d;
            wr_cnt_q      <= wr_cnt_d;
            err_q         <= err_d;
        end
    end

endmodule

// File: tb/tb_cdma_dc_rsp_unpack.sv
// Directed bench for cdma_dc_rsp_unpack. Stimulus pushes the expected CBUF
// writes / stripe pulses into a queue at accept time; a negedge monitor pops
// and compares whenever the DUT shows a write or a stripe_done pulse.
module tb_cdma_dc_rsp_unpack;
    localparam int DW = 256;
    localparam int AW = 12;

    logic            clk;
    logic            reset_;
    logic            op_en;
    logic [AW-1:0]   cfg_base_addr;
    logic [AW:0]     cfg_buf_entries;
    logic            stripe_done;
    logic [15:0]     line_cnt;
    logic [15:0]     wr_entry_cnt;
    logic            err_mask_zero;
    logic            busy;

    cdma_dc_rsp_unpack_if #(.DW(DW), .AW(AW)) bif ();

    cdma_dc_rsp_unpack #(.DW(DW), .AW(AW)) dut (
        .clk             (clk),
        .reset_          (reset_),
        .op_en           (op_en),
        .cfg_base_addr   (cfg_base_addr),
        .cfg_buf_entries (cfg_buf_entries),
        .bus             (bif),
        .stripe_done     (stripe_done),
        .line_cnt        (line_cnt),
        .wr_entry_cnt    (wr_entry_cnt),
        .err_mask_zero   (err_mask_zero),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic           is_wr;
        logic [AW-1:0]  addr;
        logic [DW-1:0]  data;
        logic           sd;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [DW-1:0] pat(input logic [31:0] s);
        return {8{s}};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one descriptor+beat, wait (bounded) for the pair to be taken,
    // queue the expected events, then drop the valids after the accept edge.
    task automatic send(input logic [1:0] mask, input logic eol, input logic eos,
                        input logic [31:0] lo, input logic [31:0] hi,
                        input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        bit got;
        got = 0;
        bif.info_pd    = {2'b00, eos, eol, mask};
        bif.rsp_pd     = {pat(hi), pat(lo)};
        bif.info_valid = 1'b1;
        bif.rsp_valid  = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (bif.info_ready && bif.rsp_ready) got = 1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL accept_timeout actual=no_accept required=accept mask=%b", mask);
        end else begin
            case (mask)
                2'b00: if (eos) sbq.push_back('{1'b0, '0, '0, 1'b1});
                2'b01: sbq.push_back('{1'b1, a0, pat(lo), eos});
                2'b10: sbq.push_back('{1'b1, a0, pat(hi), eos});
                default: begin
                    sbq.push_back('{1'b1, a0, pat(lo), 1'b0});
                    sbq.push_back('{1'b1, a1, pat(hi), eos});
                end
            endcase
        end
        @(posedge clk);
        #1;
        bif.info_valid = 1'b0;
        bif.rsp_valid  = 1'b0;
    endtask

    // Scoreboard monitor: one line per observed write/stripe event.
    always @(negedge clk) begin
        if (bif.cbuf_wr_en === 1'b1 || stripe_done === 1'b1) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event actual wr=%0b addr=%h sd=%0b required none",
                         bif.cbuf_wr_en, bif.cbuf_wr_addr, stripe_done);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                if (bif.cbuf_wr_en !== e.is_wr || stripe_done !== e.sd ||
                    (e.is_wr && (bif.cbuf_wr_addr !== e.addr || bif.cbuf_wr_data !== e.data))) begin
                    errors++;
                    $display("FAIL write_event actual wr=%0b addr=%h data=%h sd=%0b required wr=%0b addr=%h data=%h sd=%0b",
                             bif.cbuf_wr_en, bif.cbuf_wr_addr, bif.cbuf_wr_data[31:0], stripe_done,
                             e.is_wr, e.addr, e.data[31:0], e.sd);
                end else begin
                    $display("event wr=%0b addr=%h data=%h sd=%0b ok",
                             bif.cbuf_wr_en, bif.cbuf_wr_addr, bif.cbuf_wr_data[31:0], stripe_done);
                end
            end
        end
    end

    task automatic restart(input logic [AW-1:0] base, input logic [AW:0] size);
        op_en = 1'b0;
        repeat (2) tick();
        cfg_base_addr   = base;
        cfg_buf_entries = size;
        op_en = 1'b1;
        repeat (2) tick();
    endtask

    initial begin
        reset_          = 1'b1;
        op_en           = 1'b0;
        cfg_base_addr   = 12'h100;
        cfg_buf_entries = 13'd8;
        bif.info_valid  = 1'b0;
        bif.rsp_valid   = 1'b0;
        bif.info_pd     = '0;
        bif.rsp_pd      = '0;
        #2 reset_ = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_wr_en", 32'(bif.cbuf_wr_en), 0);
        chk("rst_stripe_done", 32'(stripe_done), 0);
        chk("rst_line_cnt", 32'(line_cnt), 0);
        chk("rst_wr_entry_cnt", 32'(wr_entry_cnt), 0);
        chk("rst_err", 32'(err_mask_zero), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_info_ready", 32'(bif.info_ready), 0);

        tick();
        reset_ = 1'b1;
        op_en  = 1'b1;
        repeat (2) tick();
        chk("busy_after_enable", 32'(busy), 1);

        // Three single-lower-half descriptors
        send(2'b01, 1'b0, 1'b0, 32'h1111_0001, 32'h0, 12'h100, 12'h0);
        send(2'b01, 1'b0, 1'b0, 32'h1111_0002, 32'h0, 12'h101, 12'h0);
        send(2'b01, 1'b0, 1'b0, 32'h1111_0003, 32'h0, 12'h102, 12'h0);
        repeat (3) tick();
        chk("wr_entry_cnt_3", 32'(wr_entry_cnt), 3);

        op_en = 1'b0;
        repeat (2) tick();
        chk("busy_idle", 32'(busy), 0);

        // Both halves; next descriptor is already waiting during the HI cycle
        op_en = 1'b1;
        repeat (2) tick();
        chk("cnt_cleared", 32'(wr_entry_cnt), 0);
        send(2'b11, 1'b0, 1'b0, 32'hAAAA_0000, 32'hBBBB_0000, 12'h100, 12'h101);
        bif.info_pd    = {4'b0000, 2'b10};
        bif.rsp_valid  = 1'b1;
        bif.info_valid = 1'b1;
        @(negedge clk);
        chk("info_ready_in_hi", 32'(bif.info_ready), 0);
        send(2'b10, 1'b0, 1'b0, 32'h0, 32'hCCCC_0000, 12'h102, 12'h0);
        repeat (3) tick();
        chk("wr_entry_cnt_after_hi", 32'(wr_entry_cnt), 3);

        // Ring wrap with 4 entries; last descriptor ends the stripe
        restart(12'h100, 13'd4);
        send(2'b11, 1'b0, 1'b0, 32'h0000_0001, 32'h0000_0002, 12'h100, 12'h101);
        send(2'b11, 1'b0, 1'b0, 32'h0000_0003, 32'h0000_0004, 12'h102, 12'h103);
        send(2'b11, 1'b0, 1'b1, 32'h0000_0005, 32'h0000_0006, 12'h100, 12'h101);
        repeat (3) tick();
        chk("wrap_wr_entry_cnt", 32'(wr_entry_cnt), 6);
        chk("wrap_line_cnt", 32'(line_cnt), 0);
        chk("err_clear", 32'(err_mask_zero), 0);

        // Empty mask with eol+eos
        send(2'b00, 1'b1, 1'b1, 32'h0, 32'h0, 12'h0, 12'h0);
        repeat (3) tick();
        chk("err_mask_zero_set", 32'(err_mask_zero), 1);
        chk("line_cnt_mask0", 32'(line_cnt), 1);
        chk("wr_entry_cnt_mask0", 32'(wr_entry_cnt), 6);

        // Stall: descriptor waits for its beat
        bif.info_pd    = {4'b0000, 2'b01};
        bif.rsp_pd     = {pat(32'h0), pat(32'h7777_0000)};
        bif.info_valid = 1'b1;
        bif.rsp_valid  = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stall_info_ready", 32'(bif.info_ready), 0);
        end
        chk("stall_rsp_ready", 32'(bif.rsp_ready), 1);
        tick();
        bif.rsp_valid = 1'b1;
        @(negedge clk);
        chk("unstall_info_ready", 32'(bif.info_ready), 1);
        sbq.push_back('{1'b1, 12'h102, pat(32'h7777_0000), 1'b0});
        tick();
        bif.info_valid = 1'b0;
        bif.rsp_valid  = 1'b0;
        repeat (2) tick();

        // Full address space, base at the top entry
        restart(12'hFFF, 13'd0);
        send(2'b11, 1'b0, 1'b0, 32'h0000_0008, 32'h0000_0009, 12'hFFF, 12'h000);
        repeat (3) tick();

        // op_en drops during HI: upper write still lands, then IDLE
        restart(12'h100, 13'd8);
        send(2'b11, 1'b0, 1'b0, 32'h0000_00A1, 32'h0000_00A2, 12'h100, 12'h101);
        op_en = 1'b0;
        repeat (3) tick();
        chk("drop_busy", 32'(busy), 0);
        chk("drop_wr_entry_cnt", 32'(wr_entry_cnt), 2);
        op_en = 1'b1;
        repeat (2) tick();
        chk("reenable_cnt", 32'(wr_entry_cnt), 0);
        send(2'b01, 1'b0, 1'b0, 32'h0000_00A3, 32'h0, 12'h100, 12'h0);
        repeat (2) tick();

        // Reset during HI: nothing further comes out
        send(2'b11, 1'b0, 1'b1, 32'h0000_00D1, 32'h0000_00D2, 12'h101, 12'h102);
        reset_ = 1'b0;
        op_en  = 1'b0;
        sbq.delete();
        @(negedge clk);
        chk("midrst_wr_en", 32'(bif.cbuf_wr_en), 0);
        chk("midrst_stripe_done", 32'(stripe_done), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_wr_entry_cnt", 32'(wr_entry_cnt), 0);
        chk("midrst_info_ready", 32'(bif.info_ready), 0);
        tick();
        reset_ = 1'b1;
        repeat (5) tick();
        chk("scoreboard_empty", 32'(sbq.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time bound in case anything above stalls.
    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
